// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encoding, phase length and the decoded line-event bundle.
package sccb_pkg;
  localparam int         PHASE_BITS   = 9;
  localparam int         CNT_W        = $clog2(PHASE_BITS);
  localparam logic [7:0] DEF_DEV_ADDR = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_SUB, S_WDATA, S_RDATA, S_SKIP
  } sccb_state_e;

  typedef struct packed {
    logic sda;
    logic rise;
    logic fall;
    logic start;
    logic stop;
  } sccb_line_t;
endpackage

// File: rtl/sccb_line_sync.sv
// SIO_C/SIO_D synchroniser plus clock-edge and start/stop detection on the synced lines.
module sccb_line_sync
  import sccb_pkg::*;
#(
  parameter int SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output sccb_line_t line
);
  logic [SYNC_LEN-1:0] scl_ff, sda_ff;
  logic                scl_q, sda_q;
  logic                scl_s, sda_s;

  assign scl_s = scl_ff[SYNC_LEN-1];
  assign sda_s = sda_ff[SYNC_LEN-1];

  // Idle bus is pulled high, so every stage resets to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_LEN-2:0], scl_in};
      sda_ff <= {sda_ff[SYNC_LEN-2:0], sda_in};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  // Bus conditions need SIO_C high on both sides of the SIO_D edge.
  always_comb begin
    line.sda   = sda_s;
    line.rise  = scl_s & ~scl_q;
    line.fall  = ~scl_s & scl_q;
    line.start = scl_s & scl_q & sda_q & ~sda_s;
    line.stop  = scl_s & scl_q & ~sda_q & sda_s;
  end
endmodule

// File: rtl/ov_sccb_target.sv
// SCCB responder: decodes 3-phase write, 2-phase write and 2-phase read cycles
// and drives a simple synchronous register port.
module ov_sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sio_c_in,
  input  logic       sio_d_in,
  output logic       sio_d_out,
  output logic       sio_d_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err
);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PHASE_BITS - 1);
  localparam logic [CNT_W-1:0] BYTE_BIT = CNT_W'(PHASE_BITS - 2);

  sccb_line_t       ln;
  sccb_state_e      state, nstate;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       rx_sh, tx_sh, rx_next;
  logic             extra_armed;
  logic             quiet, last_bit, byte_done, id_miss;
  logic             ld_addr, ld_wdata, enter_rd, arm_extra, err_set;

  sccb_line_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .scl_in (sio_c_in),
    .sda_in (sio_d_in),
    .line   (ln)
  );

  assign quiet     = ~ln.start & ~ln.stop;
  assign last_bit  = ln.rise && (bit_cnt == LAST_BIT);
  assign byte_done = ln.rise && (bit_cnt == BYTE_BIT);
  assign rx_next   = {rx_sh[6:0], ln.sda};
  assign id_miss   = rx_sh[7:1] != DEV_ADDR[7:1];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  // Start/stop override everything; phase transitions happen on the 9th rising edge.
  always_comb begin
    nstate = state;
    if (ln.start)     nstate = S_ID;
    else if (ln.stop) nstate = S_IDLE;
    else if (last_bit) begin
      unique case (state)
        S_ID:    nstate = id_miss ? S_SKIP : (rx_sh[0] ? S_RDATA : S_SUB);
        S_SUB:   nstate = S_WDATA;
        S_WDATA: nstate = S_SKIP;
        S_RDATA: nstate = S_SKIP;
        default: nstate = state;
      endcase
    end
  end

  always_comb begin
    ld_addr   = quiet && byte_done && (state == S_SUB);
    ld_wdata  = quiet && byte_done && (state == S_WDATA);
    enter_rd  = (nstate == S_RDATA) && (state != S_RDATA);
    arm_extra = quiet && last_bit && (state == S_WDATA || state == S_RDATA);
    err_set   = quiet && last_bit &&
                ((state == S_ID && id_miss) || (state == S_SKIP && extra_armed));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      err         <= 1'b0;
      sio_d_oe    <= 1'b0;
      sio_d_out   <= 1'b1;
      extra_armed <= 1'b0;
    end else begin
      reg_we <= ld_wdata;
      reg_re <= enter_rd;
      err    <= err_set;
      if (reg_re) tx_sh <= reg_rdata;
      if (ld_addr)  reg_addr  <= rx_next;
      if (ld_wdata) reg_wdata <= rx_next;
      if (!quiet) begin
        bit_cnt     <= '0;
        sio_d_oe    <= 1'b0;
        sio_d_out   <= 1'b1;
        extra_armed <= 1'b0;
      end else begin
        if (ln.rise && state != S_IDLE) begin
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          if (!last_bit) rx_sh <= rx_next;
        end
        if (arm_extra)    extra_armed <= 1'b1;
        else if (err_set) extra_armed <= 1'b0;
        // bit_cnt names the bit the master samples next; the 9th is left to the master.
        if (ln.fall && state == S_RDATA) begin
          if (bit_cnt == LAST_BIT) begin
            sio_d_oe  <= 1'b0;
            sio_d_out <= 1'b1;
          end else begin
            sio_d_oe  <= 1'b1;
            sio_d_out <= tx_sh[~bit_cnt[2:0]];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ov_sccb_target.sv
// Directed bench for ov_sccb_target: bit-banged SCCB master, vector table plus corner sequences.
module tb_ov_sccb_target;
  localparam int K_W3 = 0, K_W2 = 1, K_RD = 2;

  logic       clk, reset;
  logic       scl_m, sda_m;
  logic       sio_d_in, sio_d_out, sio_d_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy, err;

  int         n_chk = 0, n_err = 0;
  int         we_cnt = 0, re_cnt = 0, err_cnt = 0, oe_cnt = 0;
  logic [7:0] last_wdata = 8'h00;

  typedef struct {
    int         kind;
    logic [7:0] id, sub, data, rdata;
    int         we, re, er;
    logic [7:0] addr, wdata, rd;
  } vec_t;
  vec_t tbl[10];

  assign sio_d_in = sda_m & (sio_d_oe ? sio_d_out : 1'b1);

  ov_sccb_target dut (
    .clk(clk), .reset(reset), .sio_c_in(scl_m), .sio_d_in(sio_d_in),
    .sio_d_out(sio_d_out), .sio_d_oe(sio_d_oe), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      we_cnt  += int'(reg_we);
      re_cnt  += int'(reg_re);
      err_cnt += int'(err);
      oe_cnt  += int'(sio_d_oe);
      if (reg_we) last_wdata = reg_wdata;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Works from idle (both high) or from mid-transfer with SIO_C low.
  task automatic start_c();
    sda_m = 1'b1; wclk(4);
    scl_m = 1'b1; wclk(8);
    sda_m = 1'b0; wclk(8);
    scl_m = 1'b0; wclk(4);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wclk(4);
    scl_m = 1'b1; wclk(8);
    sda_m = 1'b1; wclk(8);
  endtask

  task automatic bit_tx(input logic b);
    sda_m = b;    wclk(4);
    scl_m = 1'b1; wclk(8);
    scl_m = 1'b0; wclk(4);
  endtask

  task automatic bit_rx(output logic b, output logic oe);
    sda_m = 1'b1; wclk(4);
    scl_m = 1'b1; wclk(4);
    b  = sio_d_in;
    oe = sio_d_oe;
    wclk(4);
    scl_m = 1'b0; wclk(4);
  endtask

  task automatic byte_w(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) bit_tx(d[i]);
    bit_tx(1'b1);
  endtask

  task automatic byte_r(output logic [7:0] d, output logic na_oe);
    logic b, oe;
    for (int i = 7; i >= 0; i--) begin
      bit_rx(b, oe);
      d[i] = b;
    end
    bit_rx(b, na_oe);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int we0, re0, er0, oe0;
    logic [7:0] rd;
    logic na;
    we0 = we_cnt; re0 = re_cnt; er0 = err_cnt; oe0 = oe_cnt;
    reg_rdata = v.rdata;
    start_c();
    byte_w(v.id);
    if (v.kind == K_RD) begin
      byte_r(rd, na);
      chk($sformatf("v%0d rd_byte", idx), int'(rd), int'(v.rd));
      chk($sformatf("v%0d na_oe", idx), int'(na), 0);
    end else begin
      byte_w(v.sub);
      if (v.kind == K_W3) byte_w(v.data);
    end
    chk($sformatf("v%0d busy_pre_stop", idx), int'(busy), 1);
    stop_c();
    wclk(4);
    chk($sformatf("v%0d busy_post", idx), int'(busy), 0);
    chk($sformatf("v%0d we_count", idx), we_cnt - we0, v.we);
    chk($sformatf("v%0d re_count", idx), re_cnt - re0, v.re);
    chk($sformatf("v%0d err_count", idx), err_cnt - er0, v.er);
    chk($sformatf("v%0d reg_addr", idx), int'(reg_addr), int'(v.addr));
    if (v.we != 0) chk($sformatf("v%0d wdata", idx), int'(last_wdata), int'(v.wdata));
    if (v.kind != K_RD) chk($sformatf("v%0d oe_cycles", idx), oe_cnt - oe0, 0);
  endtask

  initial begin
    int we0, re0, er0, oe0;
    logic [7:0] rd;
    logic b, oe, na;

    //          kind  id     sub    data   rdata  we re er addr   wdata  rd
    tbl[0] = '{K_W3, 8'h42, 8'h12, 8'h80, 8'h00, 1, 0, 0, 8'h12, 8'h80, 8'h00};
    tbl[1] = '{K_W2, 8'h42, 8'h0A, 8'h00, 8'h00, 0, 0, 0, 8'h0A, 8'h00, 8'h00};
    tbl[2] = '{K_RD, 8'h43, 8'h00, 8'h00, 8'h76, 0, 1, 0, 8'h0A, 8'h00, 8'h76};
    tbl[3] = '{K_W2, 8'h60, 8'h12, 8'h00, 8'h00, 0, 0, 1, 8'h0A, 8'h00, 8'h00};
    tbl[4] = '{K_W3, 8'h42, 8'h5A, 8'hC3, 8'h00, 1, 0, 0, 8'h5A, 8'hC3, 8'h00};
    tbl[5] = '{K_RD, 8'h43, 8'h00, 8'h00, 8'hA5, 0, 1, 0, 8'h5A, 8'h00, 8'hA5};
    tbl[6] = '{K_RD, 8'h61, 8'h00, 8'h00, 8'h3C, 0, 0, 1, 8'h5A, 8'h00, 8'hFF};
    tbl[7] = '{K_W3, 8'h42, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h00, 8'h00};
    tbl[8] = '{K_RD, 8'h43, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 8'h00, 8'h00};
    tbl[9] = '{K_RD, 8'h43, 8'h00, 8'h00, 8'hFF, 0, 1, 0, 8'hFF, 8'h00, 8'hFF};

    scl_m = 1'b1; sda_m = 1'b1; reg_rdata = 8'h00;
    reset = 1'b1;
    wclk(5);
    chk("rst sio_d_oe", int'(sio_d_oe), 0);
    chk("rst sio_d_out", int'(sio_d_out), 1);
    chk("rst reg_addr", int'(reg_addr), 0);
    chk("rst reg_we", int'(reg_we), 0);
    chk("rst reg_re", int'(reg_re), 0);
    chk("rst err", int'(err), 0);
    chk("rst busy", int'(busy), 0);
    reset = 1'b0;
    wclk(5);

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Repeated start part-way through the sub-address; only the second transfer writes.
    we0 = we_cnt; er0 = err_cnt;
    start_c();
    byte_w(8'h42);
    bit_tx(1'b1); bit_tx(1'b0); bit_tx(1'b0);
    start_c();
    byte_w(8'h42); byte_w(8'h34); byte_w(8'h55);
    stop_c(); wclk(4);
    chk("rs we_count", we_cnt - we0, 1);
    chk("rs reg_addr", int'(reg_addr), 8'h34);
    chk("rs wdata", int'(last_wdata), 8'h55);
    chk("rs err_count", err_cnt - er0, 0);

    // Extra data bytes: one write, one error pulse, never driven.
    we0 = we_cnt; er0 = err_cnt; oe0 = oe_cnt;
    start_c();
    byte_w(8'h42); byte_w(8'h21);
    byte_w(8'h11); byte_w(8'h22); byte_w(8'h33); byte_w(8'h44);
    stop_c(); wclk(4);
    chk("xb we_count", we_cnt - we0, 1);
    chk("xb wdata", int'(last_wdata), 8'h11);
    chk("xb reg_addr", int'(reg_addr), 8'h21);
    chk("xb err_count", err_cnt - er0, 1);
    chk("xb oe_cycles", oe_cnt - oe0, 0);

    // Reset while the target drives read bit 3 (0x76 -> bit 3 is 0).
    reg_rdata = 8'h76;
    start_c();
    byte_w(8'h43);
    for (int i = 0; i < 4; i++) bit_rx(b, oe);
    wclk(2);
    chk("mr oe_before_reset", int'(sio_d_oe), 1);
    chk("mr out_before_reset", int'(sio_d_out), 0);
    reset = 1'b1;
    #1;
    chk("mr oe_in_reset", int'(sio_d_oe), 0);
    chk("mr busy_in_reset", int'(busy), 0);
    chk("mr addr_in_reset", int'(reg_addr), 0);
    wclk(3);
    reset = 1'b0;
    wclk(3);
    stop_c(); wclk(4);
    re0 = re_cnt;
    start_c();
    byte_w(8'h43);
    byte_r(rd, na);
    stop_c(); wclk(4);
    chk("mr next_read", int'(rd), 8'h76);
    chk("mr next_na_oe", int'(na), 0);
    chk("mr next_re", re_cnt - re0, 1);
    chk("mr next_addr", int'(reg_addr), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
